// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the PC and fetches from a variable-latency instruction memory over a
// req/ack handshake. Fetched words go to decode through the IF/ID output
// register. A one-entry skid buffer absorbs a word that arrives while decode
// is stalled. Branch/jump redirects are accepted in every state. A redirect
// that arrives while a fetch is in flight lets that fetch finish. Its data is
// then thrown away.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   stall        hold the IF/ID output register (hazard unit)
//   redirect     one-cycle taken branch/jump pulse from EX
//   redirect_pc  redirect target, valid with redirect
//   mem_req      fetch request, held until mem_ack
//   mem_addr     fetch address, stable while mem_req is high
//   mem_ack      one-cycle completion pulse, mem_rdata valid with it
//   mem_rdata    fetched word
//   ins          instruction to decode
//   npc_o        address of ins + 4
//   ins_valid    1 = ins is a real instruction, 0 = bubble
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ins,
  output logic [31:0] npc_o,
  output logic        ins_valid
);

  // FETCH: request outstanding for pc_r.
  // HOLD : a word waits in the skid buffer for the stall to end.
  // DROP : the in-flight fetch is wrong-path. Wait for its ack, then go to pend_pc_r.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pend_pc_r;
  logic [31:0] sk_ins_r;
  logic [31:0] sk_npc_r;
  logic [31:0] ins_r;
  logic [31:0] npc_r;
  logic        valid_r;
  logic [31:0] pc_plus4_s;

  assign pc_plus4_s = pc_r + 32'd4;

  // The abandoned fetch keeps its address in DROP because pc_r only moves on ack.
  assign mem_req   = ((state_r == FETCH) || (state_r == DROP)) && !rst;
  assign mem_addr  = pc_r;
  assign ins       = ins_r;
  assign npc_o     = npc_r;
  assign ins_valid = valid_r;

  // Fetch FSM, PC, skid buffer and IF/ID output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_r      <= RESET_PC;
      pend_pc_r <= RESET_PC;
      sk_ins_r  <= 32'd0;
      sk_npc_r  <= 32'd0;
      ins_r     <= NOP_INS;
      npc_r     <= RESET_PC;
      valid_r   <= 1'b0;
    end else if (redirect) begin
      // A stalled IF/ID holds the delay slot. Otherwise load a bubble.
      if (!stall) begin
        ins_r   <= NOP_INS;
        valid_r <= 1'b0;
      end
      sk_ins_r <= 32'd0;
      sk_npc_r <= 32'd0;
      case (state_r)
        FETCH: begin
          if (mem_ack) begin
            pc_r <= redirect_pc;
          end else begin
            pend_pc_r <= redirect_pc;
            state_r   <= DROP;
          end
        end
        HOLD: begin
          pc_r    <= redirect_pc;
          state_r <= FETCH;
        end
        DROP: begin
          // When the stale fetch completes in this same cycle, go straight to the new target.
          pend_pc_r <= redirect_pc;
          if (mem_ack) begin
            pc_r    <= redirect_pc;
            state_r <= FETCH;
          end
        end
        default: begin
          pc_r    <= redirect_pc;
          state_r <= FETCH;
        end
      endcase
    end else begin
      case (state_r)
        FETCH: begin
          if (mem_ack) begin
            pc_r <= pc_plus4_s;
            if (stall) begin
              sk_ins_r <= mem_rdata;
              sk_npc_r <= pc_plus4_s;
              state_r  <= HOLD;
            end else begin
              ins_r   <= mem_rdata;
              npc_r   <= pc_plus4_s;
              valid_r <= 1'b1;
            end
          end else if (!stall) begin
            ins_r   <= NOP_INS;
            valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ins_r   <= sk_ins_r;
            npc_r   <= sk_npc_r;
            valid_r <= 1'b1;
            state_r <= FETCH;
          end
        end
        DROP: begin
          if (!stall) begin
            ins_r   <= NOP_INS;
            valid_r <= 1'b0;
          end
          if (mem_ack) begin
            pc_r    <= pend_pc_r;
            state_r <= FETCH;
          end
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage. The bench includes a random-latency
// instruction memory that returns addr ^ 32'h1234_5678. A reference model
// describes the fetch stage as a pending-word queue plus a wrong-path flag,
// and the bench compares the DUT against it every cycle.
module tb_if_stage;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] KEY = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ins;
  logic [31:0] npc_o;
  logic        ins_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_pc, m_pend;
  logic        m_wrong;
  logic [31:0] q_ins[$];
  logic [31:0] q_npc[$];
  logic [31:0] e_ins, e_npc;
  logic        e_valid;

  // Memory model state.
  logic mem_busy;
  int   mem_cnt, mem_lat, lat_min, lat_max;

  if_stage #(.RESET_PC(RPC), .NOP_INS(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins(ins), .npc_o(npc_o),
    .ins_valid(ins_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic bubble();
    e_ins   = NOP;
    e_valid = 1'b0;
  endtask

  // Apply one clock edge's worth of behaviour to the reference model.
  task automatic model_update(input logic r, input logic s, input logic rd,
                              input logic [31:0] rpc, input logic ack,
                              input logic [31:0] rdata);
    logic active;
    if (r) begin
      m_pc = RPC; m_pend = RPC; m_wrong = 1'b0;
      q_ins.delete(); q_npc.delete();
      e_ins = NOP; e_npc = RPC; e_valid = 1'b0;
    end else if (rd) begin
      active = (q_ins.size() == 0);
      q_ins.delete(); q_npc.delete();
      if (!s) bubble();
      if (active && !ack) begin
        m_wrong = 1'b1;
        m_pend  = rpc;
      end else begin
        m_pc    = rpc;
        m_wrong = 1'b0;
      end
    end else if (q_ins.size() != 0) begin
      if (!s) begin
        e_ins   = q_ins.pop_front();
        e_npc   = q_npc.pop_front();
        e_valid = 1'b1;
      end
    end else if (m_wrong) begin
      if (!s) bubble();
      if (ack) begin
        m_pc    = m_pend;
        m_wrong = 1'b0;
      end
    end else begin
      if (ack) begin
        if (s) begin
          q_ins.push_back(rdata);
          q_npc.push_back(m_pc + 32'd4);
        end else begin
          e_ins   = rdata;
          e_npc   = m_pc + 32'd4;
          e_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        bubble();
      end
    end
  endtask

  // One clock cycle: drive inputs, check the request, answer as memory, check the outputs.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    logic        exp_req;
    logic        ack;
    logic [31:0] rdata;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    exp_req = !r && (q_ins.size() == 0);
    check_eq("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    if (exp_req) check_eq("mem_addr", mem_addr, m_pc);
    ack = 1'b0;
    if (r) begin
      mem_busy = 1'b0;
    end else if (mem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_lat  = $urandom_range(lat_max, lat_min);
      end
      if (mem_cnt == mem_lat) begin
        ack      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt++;
      end
    end
    rdata     = ack ? (mem_addr ^ KEY) : $urandom();
    mem_ack   = ack;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
    model_update(r, s, rd, rpc, ack, rdata);
    check_eq("ins", ins, e_ins);
    check_eq("npc_o", npc_o, e_npc);
    check_eq("ins_valid", {31'd0, ins_valid}, {31'd0, e_valid});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_rd;
    logic rd, s, r;
    logic [31:0] tgt;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 0;
    m_pc = RPC; m_pend = RPC; m_wrong = 1'b0;
    e_ins = NOP; e_npc = RPC; e_valid = 1'b0;

    // Zero-wait memory: one instruction per cycle.
    lat_min = 0; lat_max = 0;
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

    // Fixed 3-cycle latency, including a stall with an ack arriving during it.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, (i >= 2), 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

    // Redirect mid-fetch, then a second redirect while still dropping.
    step(1'b0, 1'b0, 1'b1, 32'h8000_0200);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h8000_0300);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

    // Reset in the middle of a fetch.
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

    // PC wrap at the top of the address space.
    lat_min = 0; lat_max = 0;
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0);

    // Random latency, stalls, redirects and occasional resets.
    lat_min = 0; lat_max = 3;
    prev_rd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(199, 0) == 0);
      s  = ($urandom_range(3, 0) == 0);
      rd = !prev_rd && ($urandom_range(9, 0) == 0);
      tgt = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      step(r, s, rd, tgt);
      prev_rd = rd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
